adc_uart_framer: RTL and testbench
==================================

Name: adc_uart_framer

Overview:
Packs simultaneous 10-bit samples from the four hydrophone ADC channels into fixed 8-byte frames. Streams the frames byte-by-byte to the UART transmitter through a valid/ready byte handshake. Sits between the four SPI sample receivers and the UART TX path, replacing the byte-echo controller as the host-bound data source. Provides optional decimation, a one-frame pending buffer and drop accounting.

Parameters:
SYNC_BYTE, 8'hA5, first byte of every frame.
DECIM, 1, send one frame per DECIM accepted sample sets; legal range 1..255.

Ports:
clk  input  1  system clock; all logic on its rising edge.
reset  input  1  synchronous, active-high reset.
stream_en  input  1  enables capture of new sample sets.
sample_valid  input  1  one-cycle strobe: ch1..ch4 hold a new simultaneous sample set.
ch1  input  10  channel 1 sample.
ch2  input  10  channel 2 sample.
ch3  input  10  channel 3 sample.
ch4  input  10  channel 4 sample.
tx_data  output  8  byte offered to the UART TX.
tx_valid  output  1  tx_data is valid.
tx_ready  input  1  UART TX accepts a byte this cycle.
frame_busy  output  1  high while a frame is being sent (state != IDLE).
drop_count  output  8  count of dropped frame sets; saturates at 255.

Behaviour:
- Reset (sync, high): tx_valid=0, tx_data=0, frame_busy=0, drop_count=0, seq=0, decim counter=0, pending empty, state=IDLE. Reset mid-frame aborts the frame. tx_valid is 0 from the next edge onward.
- Capture qualification:
  - sample_valid with stream_en=0 is ignored; the decim counter does not advance.
  - On an accepted pulse: if decim_cnt==DECIM-1, the set is a frame set and decim_cnt goes to 0; otherwise decim_cnt increments.
  - Channel values are latched at the strobe edge; later input changes have no effect.
- Frame format:
  - P={ch1,ch2,ch3,ch4} (40 bits).
  - byte0=SYNC_BYTE; byte1=P[39:32]; byte2=P[31:24]; byte3=P[23:16]; byte4=P[15:8]; byte5=P[7:0].
  - byte6=seq; byte7=XOR of byte0..byte6.
  - seq is 8-bit. It is assigned when a set is loaded into the frame register, then increments, wrapping FF->00.
- States:
  - IDLE: a frame set loads the frame register and the state goes to SEND with idx=0. tx_valid=1 and tx_data=byte0 in the next cycle (one-cycle latency).
  - SEND: tx_data=byte[idx]. A byte is accepted on an edge where tx_valid&&tx_ready. tx_data is stable while tx_valid&&!tx_ready. After acceptance the next byte is presented the following cycle with no bubble.
  - After byte7 is accepted: if the pending buffer is full, it moves to the frame register and byte0 of the new frame is presented next cycle (no bubble). Otherwise tx_valid=0 and the state goes to IDLE.
- Frame set arriving while in SEND: stored in pending if pending is empty. If pending is full, the set is dropped and drop_count increments (saturating). Dropped sets still advance decim_cnt.
- Simultaneous events at the byte7-accept edge:
  - Pending empty plus a frame set: the set loads the frame register directly.
  - Pending full plus a frame set: pending moves to the frame register and the new set goes to pending; no drop.
- stream_en deasserted mid-frame: the current frame and any pending frame complete; no new captures.

Test Plan:
- DECIM=1, tx_ready=1, ch1=0x3FF, ch2=0x000, ch3=0x155, ch4=0x2AA, one sample_valid -> tx_valid high for 8 consecutive cycles starting one cycle after the strobe. Bytes: A5 FF C0 05 56 AA 00 63; then tx_valid=0 and frame_busy=0.
- Same stimulus, tx_ready held low for 5 cycles while byte3 is offered -> tx_data held at 0x05 throughout; the frame then completes intact.
- tx_ready=0, three sample_valid pulses 2 cycles apart -> drop_count=1. On releasing tx_ready: 16 bytes back-to-back, seq 00 then 01, checksums correct, no idle cycle between frames.
- DECIM=4, 8 pulses with ch1=1..8 (others 0) -> exactly 2 frames, carrying ch1=4 and ch1=8.
- Pulses with stream_en=0 -> no output, decim_cnt unchanged. 257 frames with stream_en=1 -> seq wraps, so frame 257 has seq=00. 300 drops -> drop_count=255.
- Assert reset during byte4 of a frame -> tx_valid=0 and all outputs at reset values next cycle. The next frame starts with seq=00.

Source files
------------

// File: rtl/adc_uart_framer_if.sv
// Byte stream handshake between the ADC frame packer and the UART transmitter.
//   tx_data  : byte offered to the UART TX
//   tx_valid : tx_data holds a valid byte
//   tx_ready : UART TX takes the byte on this rising edge
// master = byte source (framer), slave = byte sink (UART TX).
interface adc_uart_framer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/adc_uart_framer.sv
// Packs simultaneous 10-bit samples of four hydrophone channels into 8-byte frames
// (sync, 5 payload bytes, sequence, XOR checksum) and streams them to the UART TX.
// Supports decimation, one pending frame behind the frame being sent, and a
// saturating count of frame sets dropped because both slots were occupied.
//   clk, reset        : clock and synchronous active-high reset
//   stream_en         : allows new sample sets to be captured
//   sample_valid      : one-cycle strobe, ch1..ch4 hold a new sample set
//   ch1..ch4          : 10-bit channel samples
//   tx                : byte handshake towards the UART TX (master side)
//   frame_busy        : a frame is being sent
//   drop_count        : dropped frame sets, saturating at 255
module adc_uart_framer #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned DECIM     = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stream_en,
    input  logic                     sample_valid,
    input  logic [9:0]               ch1,
    input  logic [9:0]               ch2,
    input  logic [9:0]               ch3,
    input  logic [9:0]               ch4,
    adc_uart_framer_if.master        tx,
    output logic                     frame_busy,
    output logic [7:0]               drop_count
);

    typedef enum logic [0:0] {StIdle, StSend} state_e;
    typedef logic [7:0][7:0] frame_t;

    localparam logic [7:0] DecimLast = 8'(DECIM - 1);

    state_e      state_q, state_d;
    frame_t      frame_q, frame_d;
    logic [2:0]  idx_q, idx_d;
    logic [39:0] pend_q, pend_d;
    logic        pend_full_q, pend_full_d;
    logic [7:0]  seq_q, seq_d;
    logic [7:0]  decim_q, decim_d;
    logic [7:0]  drop_q, drop_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;

    logic [39:0] sample_set;
    logic        accept_set, frame_set, byte_acc, last_acc;

    function automatic frame_t build_frame(input logic [39:0] p, input logic [7:0] s);
        frame_t f;
        f[0] = SYNC_BYTE;
        f[1] = p[39:32];
        f[2] = p[31:24];
        f[3] = p[23:16];
        f[4] = p[15:8];
        f[5] = p[7:0];
        f[6] = s;
        f[7] = f[0] ^ f[1] ^ f[2] ^ f[3] ^ f[4] ^ f[5] ^ f[6];
        return f;
    endfunction

    assign sample_set = {ch1, ch2, ch3, ch4};
    assign accept_set = stream_en && sample_valid;
    assign frame_set  = accept_set && (decim_q == DecimLast);
    assign byte_acc   = tx_valid_q && tx.tx_ready;
    assign last_acc   = byte_acc && (idx_q == 3'd7);

    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        idx_d       = idx_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        seq_d       = seq_q;
        decim_d     = decim_q;
        drop_d      = drop_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;

        // Dropped sets still advance the decimation phase.
        if (accept_set) begin
            decim_d = frame_set ? 8'd0 : decim_q + 8'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (frame_set) begin
                    frame_d    = build_frame(sample_set, seq_q);
                    seq_d      = seq_q + 8'd1;
                    idx_d      = 3'd0;
                    tx_valid_d = 1'b1;
                    tx_data_d  = SYNC_BYTE;
                    state_d    = StSend;
                end
            end
            StSend: begin
                if (last_acc) begin
                    // Pending set goes first; a fresh set either loads directly or
                    // takes the slot pending just vacated, so nothing drops here.
                    if (pend_full_q || frame_set) begin
                        frame_d     = build_frame(pend_full_q ? pend_q : sample_set, seq_q);
                        seq_d       = seq_q + 8'd1;
                        idx_d       = 3'd0;
                        tx_data_d   = SYNC_BYTE;
                        pend_full_d = pend_full_q && frame_set;
                        if (frame_set) begin
                            pend_d = sample_set;
                        end
                    end else begin
                        tx_valid_d = 1'b0;
                        state_d    = StIdle;
                    end
                end else begin
                    if (byte_acc) begin
                        idx_d     = idx_q + 3'd1;
                        tx_data_d = frame_q[idx_q + 3'd1];
                    end
                    if (frame_set) begin
                        if (!pend_full_q) begin
                            pend_d      = sample_set;
                            pend_full_d = 1'b1;
                        end else if (drop_q != 8'hFF) begin
                            drop_d = drop_q + 8'd1;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            frame_q     <= '0;
            idx_q       <= 3'd0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            seq_q       <= 8'd0;
            decim_q     <= 8'd0;
            drop_q      <= 8'd0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            idx_q       <= idx_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            seq_q       <= seq_d;
            decim_q     <= decim_d;
            drop_q      <= drop_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
        end
    end

    assign tx.tx_valid = tx_valid_q;
    assign tx.tx_data  = tx_data_q;
    assign frame_busy  = (state_q == StSend);
    assign drop_count  = drop_q;

endmodule

// File: tb/tb_adc_uart_framer.sv
// Self-checking bench for adc_uart_framer. dut1 (DECIM=1) is tracked every cycle
// by a queue-based reference model; dut4 (DECIM=4) is checked on its byte stream.
module tb_adc_uart_framer;

    logic       clk = 1'b0;
    logic       reset;
    logic       stream_en;
    logic       sample_valid;
    logic [9:0] ch1, ch2, ch3, ch4;
    logic       ready;
    logic       frame_busy1, frame_busy4;
    logic [7:0] drop1, drop4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    adc_uart_framer_if if1 ();
    adc_uart_framer_if if4 ();

    assign if1.tx_ready = ready;
    assign if4.tx_ready = 1'b1;

    adc_uart_framer #(.SYNC_BYTE(8'hA5), .DECIM(1)) dut1 (
        .clk          (clk),
        .reset        (reset),
        .stream_en    (stream_en),
        .sample_valid (sample_valid),
        .ch1          (ch1),
        .ch2          (ch2),
        .ch3          (ch3),
        .ch4          (ch4),
        .tx           (if1),
        .frame_busy   (frame_busy1),
        .drop_count   (drop1)
    );

    adc_uart_framer #(.SYNC_BYTE(8'hA5), .DECIM(4)) dut4 (
        .clk          (clk),
        .reset        (reset),
        .stream_en    (stream_en),
        .sample_valid (sample_valid),
        .ch1          (ch1),
        .ch2          (ch2),
        .ch3          (ch3),
        .ch4          (ch4),
        .tx           (if4),
        .frame_busy   (frame_busy4),
        .drop_count   (drop4)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame as 64 bits, byte 0 in the top byte.
    function automatic logic [63:0] mk_frame(input logic [39:0] p, input int s);
        logic [7:0] b [8];
        logic [63:0] f;
        b[0] = 8'hA5;
        for (int k = 1; k <= 5; k++) b[k] = 8'((p >> (8 * (5 - k))) & 40'hFF);
        b[6] = 8'(s % 256);
        b[7] = 8'h00;
        for (int k = 0; k < 7; k++) b[7] = b[7] ^ b[k];
        f = 64'd0;
        for (int k = 0; k < 8; k++) f = (f << 8) | 64'(b[k]);
        return f;
    endfunction

    function automatic logic [7:0] byte_of(input logic [63:0] f, input int k);
        return 8'((f >> (8 * (7 - k))) & 64'hFF);
    endfunction

    // Reference model: frames owed to the host (in-flight plus pending, at most two).
    logic [63:0] mq[$];
    int          m_idx = 0;
    int          m_seq = 0;
    int          m_drop = 0;
    int          m_dcnt = 0;
    bit          m_rst = 1'b0;
    localparam int MDecim = 1;

    bit          collect = 1'b0;
    logic [7:0]  obs[$];
    logic [7:0]  obs4[$];

    always @(posedge clk) begin
        if (collect && if1.tx_valid && if1.tx_ready) obs.push_back(if1.tx_data);
        if (if4.tx_valid) obs4.push_back(if4.tx_data);
        if (reset) begin
            mq.delete();
            m_idx  = 0;
            m_seq  = 0;
            m_drop = 0;
            m_dcnt = 0;
            m_rst  = 1'b1;
        end else begin
            m_rst = 1'b0;
            if (mq.size() > 0 && ready) begin
                m_idx++;
                if (m_idx == 8) begin
                    void'(mq.pop_front());
                    m_idx = 0;
                end
            end
            if (stream_en && sample_valid) begin
                m_dcnt++;
                if (m_dcnt == MDecim) begin
                    m_dcnt = 0;
                    if (mq.size() < 2) begin
                        mq.push_back(mk_frame({ch1, ch2, ch3, ch4}, m_seq));
                        m_seq = (m_seq + 1) % 256;
                    end else if (m_drop < 255) begin
                        m_drop++;
                    end
                end
            end
        end
        #1;
        check_eq("tx_valid", 32'(if1.tx_valid), 32'(mq.size() > 0));
        check_eq("frame_busy", 32'(frame_busy1), 32'(mq.size() > 0));
        check_eq("drop_count", 32'(drop1), 32'(m_drop));
        if (mq.size() > 0) check_eq("tx_data", 32'(if1.tx_data), 32'(byte_of(mq[0], m_idx)));
        if (m_rst) check_eq("tx_data_rst", 32'(if1.tx_data), 32'h0);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c,
                         input logic [9:0] d, input bit en);
        @(negedge clk);
        stream_en    = en;
        ch1          = a;
        ch2          = b;
        ch3          = c;
        ch4          = d;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        stream_en    = 1'b1;
        ch1          = 10'($urandom_range(1023));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] exp1 [8];
        logic [7:0] exp2 [8];
        logic [7:0] x;
        bit         found;
        exp1 = '{8'hA5, 8'hFF, 8'hC0, 8'h05, 8'h56, 8'hAA, 8'h00, 8'h63};
        exp2 = '{8'hA5, 8'hFF, 8'hC0, 8'h05, 8'h56, 8'hAA, 8'h01, 8'h62};
        reset = 1'b1; stream_en = 1'b1; sample_valid = 1'b0; ready = 1'b1;
        ch1 = '0; ch2 = '0; ch3 = '0; ch4 = '0;
        cyc(3);
        reset = 1'b0;

        // Known-answer frame.
        obs.delete(); collect = 1'b1;
        pulse(10'h3FF, 10'h000, 10'h155, 10'h2AA, 1'b1);
        cyc(10); collect = 1'b0;
        check_eq("kat_len", 32'(obs.size()), 32'd8);
        if (obs.size() == 8) for (int k = 0; k < 8; k++) check_eq("kat_byte", 32'(obs[k]), 32'(exp1[k]));
        check_eq("kat_busy_end", 32'(frame_busy1), 32'd0);

        // Back-pressure while byte3 is offered.
        obs.delete(); collect = 1'b1;
        pulse(10'h3FF, 10'h000, 10'h155, 10'h2AA, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (if1.tx_valid && if1.tx_data == 8'h05) found = 1'b1;
            else @(negedge clk);
        end
        check_eq("stall_found", 32'(found), 32'd1);
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("stall_hold", 32'(if1.tx_data), 32'h05);
        end
        ready = 1'b1;
        cyc(10); collect = 1'b0;
        check_eq("stall_len", 32'(obs.size()), 32'd8);
        if (obs.size() == 8) for (int k = 0; k < 8; k++) check_eq("stall_byte", 32'(obs[k]), 32'(exp2[k]));

        // Pending plus a drop, then back-to-back frames.
        do_reset();
        ready = 1'b0;
        pulse(10'h011, 10'h022, 10'h033, 10'h044, 1'b1); cyc(1);
        pulse(10'h155, 10'h2AA, 10'h0F0, 10'h30F, 1'b1); cyc(1);
        pulse(10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 1'b1);
        check_eq("drop_one", 32'(drop1), 32'd1);
        obs.delete(); collect = 1'b1;
        @(negedge clk) ready = 1'b1;
        cyc(20); collect = 1'b0;
        check_eq("b2b_len", 32'(obs.size()), 32'd16);
        if (obs.size() == 16) begin
            check_eq("b2b_seq0", 32'(obs[6]), 32'h00);
            check_eq("b2b_seq1", 32'(obs[14]), 32'h01);
            for (int f = 0; f < 2; f++) begin
                x = 8'h00;
                for (int k = 0; k < 8; k++) x = x ^ obs[8 * f + k];
                check_eq("b2b_xor", 32'(x), 32'h00);
            end
        end

        // Decimation by 4 on dut4, with disabled strobes that must not count.
        do_reset();
        obs4.delete();
        for (int i = 1; i <= 8; i++) begin
            pulse(10'(i), 10'h000, 10'h000, 10'h000, 1'b1);
            cyc(2);
            if (i == 2) begin
                pulse(10'h3F0, 10'h000, 10'h000, 10'h000, 1'b0);
                pulse(10'h3F0, 10'h000, 10'h000, 10'h000, 1'b0);
            end
        end
        cyc(20);
        check_eq("decim_len", 32'(obs4.size()), 32'd16);
        if (obs4.size() == 16) begin
            for (int k = 0; k < 8; k++) begin
                check_eq("decim_f0", 32'(obs4[k]), 32'(byte_of(mk_frame({10'd4, 30'd0}, 0), k)));
                check_eq("decim_f1", 32'(obs4[8 + k]), 32'(byte_of(mk_frame({10'd8, 30'd0}, 1), k)));
            end
        end
        check_eq("decim_drop", 32'(drop4), 32'd0);
        check_eq("decim_busy", 32'(frame_busy4), 32'd0);

        // Sequence wrap: frame 257 carries seq 00.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            pulse(10'($urandom_range(1023)), 10'($urandom_range(1023)),
                  10'($urandom_range(1023)), 10'($urandom_range(1023)), 1'b1);
            cyc(8);
        end
        obs.delete(); collect = 1'b1;
        pulse(10'h123, 10'h234, 10'h345, 10'h056, 1'b1);
        cyc(10); collect = 1'b0;
        check_eq("wrap_len", 32'(obs.size()), 32'd8);
        if (obs.size() == 8) check_eq("wrap_seq", 32'(obs[6]), 32'h00);

        // Drop counter saturation.
        do_reset();
        ready = 1'b0;
        @(negedge clk);
        sample_valid = 1'b1;
        for (int i = 0; i < 302; i++) begin
            ch2 = 10'($urandom_range(1023));
            @(negedge clk);
        end
        sample_valid = 1'b0;
        check_eq("drop_sat", 32'(drop1), 32'd255);
        ready = 1'b1;
        cyc(20);

        // Reset while byte4 is offered.
        do_reset();
        pulse(10'h2AA, 10'h155, 10'h3FF, 10'h001, 1'b1);
        cyc(4);
        check_eq("mid_idx4", 32'(if1.tx_data), 32'(byte_of(mk_frame({10'h2AA, 10'h155, 10'h3FF, 10'h001}, 0), 4)));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("rst_valid", 32'(if1.tx_valid), 32'd0);
        check_eq("rst_data", 32'(if1.tx_data), 32'd0);
        check_eq("rst_busy", 32'(frame_busy1), 32'd0);
        check_eq("rst_drop", 32'(drop1), 32'd0);
        obs.delete(); collect = 1'b1;
        pulse(10'h0AB, 10'h0CD, 10'h0EF, 10'h012, 1'b1);
        cyc(10); collect = 1'b0;
        check_eq("rst_len", 32'(obs.size()), 32'd8);
        if (obs.size() == 8) check_eq("rst_seq", 32'(obs[6]), 32'h00);

        // Random traffic, checked by the model every cycle.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            reset        = ($urandom_range(199) == 0);
            stream_en    = ($urandom_range(7) != 0);
            sample_valid = ($urandom_range(3) == 0);
            ready        = ($urandom_range(3) != 0);
            ch1 = 10'($urandom_range(1023));
            ch2 = 10'($urandom_range(1023));
            ch3 = 10'($urandom_range(1023));
            ch4 = 10'($urandom_range(1023));
        end
        @(negedge clk);
        reset = 1'b0; sample_valid = 1'b0; ready = 1'b1;
        cyc(30);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
